// File: rtl/count_cycle_cw16.sv
// count_cycle_cw16: stream beat counter behind a 2-entry skid buffer; every beat carries its count and a terminal-count flag
// Ports:
//   clk, sync_reset_n              clock, synchronous active-low reset
//   s_axis_tvalid/tdata/tuser/tlast  upstream beat; s_axis_tready is registered
//   cnt_limit                      terminal count (payload length minus 1), sampled at acceptance
//   m_axis_tvalid/tdata/tuser/tlast  downstream beat; m_axis_tready from downstream
//   m_axis_final_cnt, count        terminal-count flag and count value of the output beat
// Option: define COUNT_CYCLE_TLAST_RESYNC_EN so an accepted tlast beat restarts the counter at 0.
module count_cycle_cw16 #(
  parameter int DATA_WIDTH  = 32,
  parameter int TUSER_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   sync_reset_n,
  input  logic                   s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,
  input  logic [15:0]            cnt_limit,
  output logic                   m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                   m_axis_tlast,
  output logic                   m_axis_final_cnt,
  output logic [15:0]            count,
  input  logic                   m_axis_tready
);
  localparam int BW = DATA_WIDTH + TUSER_WIDTH + 18;
  logic [BW-1:0] out_q, skid_q, beat, out_d, skid_d;
  logic out_v, skid_v, out_v_d, skid_v_d, rdy, acc, dlv, fin;
  logic [15:0] cnt, cnt_d;
  assign s_axis_tready = rdy;
  assign m_axis_tvalid = out_v;
  assign {m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_final_cnt, count} = out_q;
  always_comb begin
    acc = s_axis_tvalid & rdy;
    dlv = out_v & m_axis_tready;
    fin = cnt >= cnt_limit;
`ifdef COUNT_CYCLE_TLAST_RESYNC_EN
    cnt_d = acc ? ((fin | s_axis_tlast) ? 16'd0 : cnt + 16'd1) : cnt;
`else
    cnt_d = acc ? (fin ? 16'd0 : cnt + 16'd1) : cnt;
`endif
    beat = {s_axis_tdata, s_axis_tuser, s_axis_tlast, fin, cnt};
    out_d = out_q;
    skid_d = skid_q;
    out_v_d = out_v;
    skid_v_d = skid_v;
    // The output register refills from the skid entry first so beats stay in order;
    // the skid entry only fills while the output is held by downstream backpressure.
    if (!out_v || dlv) begin
      out_d = skid_v ? skid_q : beat;
      out_v_d = skid_v | acc;
      skid_d = beat;
      skid_v_d = skid_v & acc;
    end else if (acc) begin
      skid_d = beat;
      skid_v_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      out_q <= '0;
      skid_q <= '0;
      out_v <= 1'b0;
      skid_v <= 1'b0;
      rdy <= 1'b0;
      cnt <= '0;
    end else begin
      out_q <= out_d;
      skid_q <= skid_d;
      out_v <= out_v_d;
      skid_v <= skid_v_d;
      rdy <= ~skid_v_d;
      cnt <= cnt_d;
    end
  end
endmodule

// File: tb/tb_count_cycle_cw16.sv
// tb_count_cycle_cw16: directed self-checking bench for count_cycle_cw16
module tb_count_cycle_cw16;
  logic clk = 1'b0;
  logic sync_reset_n, s_tvalid, s_tlast, s_tready, m_tvalid, m_tlast, m_final, m_tready;
  logic [31:0] s_tdata, m_tdata;
  logic [15:0] s_tuser, m_tuser, cnt_limit, count;
  int passes = 0, total = 0;
  always #5 clk = ~clk;
  count_cycle_cw16 dut (
    .clk(clk), .sync_reset_n(sync_reset_n),
    .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready), .cnt_limit(cnt_limit),
    .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser),
    .m_axis_tlast(m_tlast), .m_axis_final_cnt(m_final), .count(count),
    .m_axis_tready(m_tready)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    sync_reset_n = 1'b0;
    s_tvalid = 1'b0;
    tick;
    tick;
    sync_reset_n = 1'b1;
    tick;
  endtask
  initial begin
    logic acc, hold;
    logic [64:0] held;
    int sent, got, nf, bad;
    logic [15:0] last_fin;
    sync_reset_n = 1'b0;
    s_tvalid = 1'b0;
    s_tdata = '0;
    s_tuser = 16'hA5A5;
    s_tlast = 1'b0;
    cnt_limit = 16'd3;
    m_tready = 1'b1;
    tick;
    tick;
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tready", 64'(s_tready), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_final", 64'(m_final), 64'd0);
    check("rst_tlast", 64'(m_tlast), 64'd0);
    sync_reset_n = 1'b1;
    tick;
    check("rel_tready", 64'(s_tready), 64'd1);
    // continuous stream, limit 3: one output per cycle, one cycle after input
    s_tvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_tdata = 32'(i);
      tick;
      check("cont_beat", {31'd0, m_tvalid, m_tdata, count[7:0], m_final},
            {31'd0, 1'b1, 32'(i), 8'(i % 4), 1'(i % 4 == 3)});
    end
    check("cont_tuser", 64'(m_tuser), 64'hA5A5);
    s_tvalid = 1'b0;
    tick;
    check("cont_drain", 64'(m_tvalid), 64'd0);
    // random backpressure, limit 7, 1000 beats
    cnt_limit = 16'd7;
    sent = 0;
    got = 0;
    s_tvalid = 1'b1;
    s_tdata = 32'd0;
    m_tready = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 6000 && got < 1000; cyc++) begin
      acc = s_tvalid & s_tready;
      if (m_tvalid && m_tready) begin
        check("stall_beat", {15'd0, m_tdata, count, m_final},
              {15'd0, 32'(got), 16'(got % 8), 1'(got % 8 == 7)});
        got++;
      end
      hold = m_tvalid & ~m_tready;
      held = {m_tdata, count, m_final, m_tuser};
      tick;
      if (hold) check("stall_hold", {m_tvalid, m_tdata, count, m_final, m_tuser}, {1'b1, held[63:0]});
      if (acc) sent++;
      s_tvalid = sent < 1000;
      s_tdata = 32'(sent);
      m_tready = 1'($urandom_range(0, 1));
    end
    check("stall_all", 64'(got), 64'd1000);
    m_tready = 1'b1;
    s_tvalid = 1'b0;
    tick;
    tick;
    // limit 0: every beat final with count 0
    cnt_limit = 16'd0;
    s_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_tdata = 32'(100 + i);
      tick;
      check("lim0_beat", {m_tdata, count, m_final}, {32'(100 + i), 16'd0, 1'b1});
    end
    s_tvalid = 1'b0;
    tick;
    // skid fill: tready drops only with both entries full
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata = 32'hA;
    tick;
    check("skid_one_rdy", 64'(s_tready), 64'd1);
    s_tdata = 32'hB;
    tick;
    check("skid_full_rdy", 64'(s_tready), 64'd0);
    check("skid_full_out", 64'(m_tdata), 64'hA);
    s_tdata = 32'hC;
    m_tready = 1'b1;
    tick;
    check("skid_drain", {s_tready, m_tdata}, {1'b1, 32'hB});
    tick;
    check("skid_next", {m_tvalid, m_tdata}, {1'b1, 32'hC});
    s_tvalid = 1'b0;
    tick;
    check("skid_empty", 64'(m_tvalid), 64'd0);
    // limit lowered from 9 to 2 at count 5
    do_reset;
    cnt_limit = 16'd9;
    s_tvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_tdata = 32'(i);
      tick;
      check("lim9_beat", {count, m_final}, {16'(i), 1'b0});
    end
    cnt_limit = 16'd2;
    tick;
    check("lower_final", {count, m_final}, {16'd6, 1'b1});
    tick;
    check("lower_wrap", {count, m_final}, {16'd0, 1'b0});
    // reset mid-frame after 4 beats
    do_reset;
    cnt_limit = 16'd9;
    s_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) tick;
    check("pre_rst_count", 64'(count), 64'd3);
    sync_reset_n = 1'b0;
    s_tvalid = 1'b0;
    tick;
    check("mid_rst", {m_tvalid, s_tready, count}, {1'b0, 1'b0, 16'd0});
    sync_reset_n = 1'b1;
    tick;
    check("mid_rel_rdy", 64'(s_tready), 64'd1);
    s_tvalid = 1'b1;
    tick;
    check("post_rst_beat", {m_tvalid, count}, {1'b1, 16'd0});
    // tlast on count 2
    tick;
    s_tlast = 1'b1;
    tick;
    check("tlast_beat", {m_tlast, count}, {1'b1, 16'd2});
    s_tlast = 1'b0;
    tick;
`ifdef COUNT_CYCLE_TLAST_RESYNC_EN
    check("tlast_next", {m_tlast, count}, {1'b0, 16'd0});
`else
    check("tlast_next", {m_tlast, count}, {1'b0, 16'd3});
`endif
    // full 16-bit sweep
    do_reset;
    cnt_limit = 16'hFFFF;
    s_tvalid = 1'b1;
    nf = 0;
    bad = 0;
    last_fin = '0;
    for (int i = 0; i < 65536; i++) begin
      tick;
      if (m_final) begin
        nf++;
        last_fin = count;
      end
      if (count != 16'(i) || !m_tvalid) bad++;
    end
    tick;
    check("sweep_finals", 64'(nf), 64'd1);
    check("sweep_fin_cnt", 64'(last_fin), 64'hFFFF);
    check("sweep_seq", 64'(bad), 64'd0);
    check("sweep_wrap", {m_final, count}, {1'b0, 16'd0});
    s_tvalid = 1'b0;
    tick;
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
